top: RTL and testbench

Single-cycle 8-bit processor top level that runs a fixed program from an internal instruction ROM. The program adds the two bytes at data-memory addresses 0 and 1 and writes the sum back to address 0. It contains a register file instance `RF1` and a data memory instance `DM1`. Benches preload both before starting, then wait for `done`.

---
 rtl/top.sv | 124 ++++++++++++
 tb/tb_top.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/top.sv
// Single-cycle 8-bit processor running a fixed ROM program that adds DM[0] and DM[1] into DM[0].
// Holds the register file (RF1), the data memory (DM1), PC and the sticky done flag.

module regfile (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_we,
  input  logic [2:0] i_wa,
  input  logic [7:0] i_wd,
  input  logic [2:0] i_ra_a,
  input  logic [2:0] i_ra_b,
  output logic [7:0] o_rd_a,
  output logic [7:0] o_rd_b
);
  logic [7:0] core [0:7];

  // Writes are suppressed while reset is low; the array itself is never cleared.
  always @(posedge clk or negedge i_rst_n)
    if (i_rst_n && i_we) core[i_wa] <= i_wd;

  assign o_rd_a = core[i_ra_a];
  assign o_rd_b = core[i_ra_b];
endmodule

module dmem (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_we,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_wd,
  output logic [7:0] o_rd
);
  logic [7:0] core [0:255];

  always @(posedge clk or negedge i_rst_n)
    if (i_rst_n && i_we) core[i_addr] <= i_wd;

  assign o_rd = core[i_addr];
endmodule

module top (
  input  logic clk,
  input  logic reset,
  output logic done
);
  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_MOV   = 3'b100;
  localparam logic [2:0] OP_HALT  = 3'b111;

  logic [3:0] r_pc;
  logic       r_done;
  logic [8:0] w_instr;
  logic [2:0] w_op, w_a, w_b;
  logic [7:0] w_ra, w_rb, w_dm_rd;
  logic [7:0] w_rf_wd;
  logic       w_rf_we, w_dm_we, w_halt;

  always_comb begin
    w_instr = 9'b111_000_000;
    case (r_pc)
      4'd0: w_instr = 9'b000_010_110;
      4'd1: w_instr = 9'b000_011_001;
      4'd2: w_instr = 9'b010_010_011;
      4'd3: w_instr = 9'b001_010_110;
      default: w_instr = 9'b111_000_000;
    endcase
  end

  assign w_op   = w_instr[8:6];
  assign w_a    = w_instr[5:3];
  assign w_b    = w_instr[2:0];
  assign w_halt = (w_op == OP_HALT);

  always_comb begin
    w_rf_we = 1'b0;
    w_dm_we = 1'b0;
    w_rf_wd = w_ra;
    case (w_op)
      OP_LOAD:  begin w_rf_we = 1'b1; w_rf_wd = w_dm_rd;     end
      OP_STORE: begin w_dm_we = 1'b1;                        end
      OP_ADD:   begin w_rf_we = 1'b1; w_rf_wd = w_ra + w_rb; end
      OP_SUB:   begin w_rf_we = 1'b1; w_rf_wd = w_ra - w_rb; end
      OP_MOV:   begin w_rf_we = 1'b1; w_rf_wd = w_rb;        end
      default:  ;
    endcase
  end

  regfile RF1 (
    .clk    (clk),
    .i_rst_n(reset),
    .i_we   (w_rf_we),
    .i_wa   (w_a),
    .i_wd   (w_rf_wd),
    .i_ra_a (w_a),
    .i_ra_b (w_b),
    .o_rd_a (w_ra),
    .o_rd_b (w_rb)
  );

  dmem DM1 (
    .clk    (clk),
    .i_rst_n(reset),
    .i_we   (w_dm_we),
    .i_addr (w_rb),
    .i_wd   (w_ra),
    .o_rd   (w_dm_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc   <= 4'd0;
      r_done <= 1'b0;
    end else if (w_halt) begin
      r_done <= 1'b1;
    end else begin
      r_pc <= r_pc + 4'd1;
    end
  end

  assign done = r_done;
endmodule

// File: tb/tb_top.sv
// Bench for top: preloads RF/DM, runs the add program and compares against a plain-arithmetic model.
// Covers reset hold, mid-run reset, overflow, zero operands, sticky halt and random operands.

module tb_top;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic done;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] m_dm [256];
  logic [7:0] m_rf [8];

  top dut (.clk(clk), .reset(reset), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Environment preload: random background contents plus the program's pointer registers.
  task automatic preload(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < 256; i++) m_dm[i] = 8'($urandom);
    for (int i = 0; i < 8; i++)   m_rf[i] = 8'($urandom);
    m_dm[0] = a;
    m_dm[1] = b;
    m_rf[6] = 8'd0;
    m_rf[1] = 8'd1;
    m_rf[7] = 8'd0;
    for (int i = 0; i < 256; i++) dut.DM1.core[i] = m_dm[i];
    for (int i = 0; i < 8; i++)   dut.RF1.core[i] = m_rf[i];
  endtask

  task automatic cmp_arrays(input string tag);
    int bad_dm, bad_rf;
    bad_dm = 0;
    bad_rf = 0;
    for (int i = 0; i < 256; i++) if (dut.DM1.core[i] !== m_dm[i]) bad_dm++;
    for (int i = 0; i < 8; i++)   if (dut.RF1.core[i] !== m_rf[i]) bad_rf++;
    chk({tag, "_dm_diffs"}, bad_dm, 0);
    chk({tag, "_rf_diffs"}, bad_rf, 0);
  endtask

  // Releases reset and returns the edge number on which done was first seen (0 = never).
  task automatic release_and_run(output int done_edge);
    done_edge = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 && done_edge == 0) done_edge = e;
    end
  endtask

  task automatic apply_model_result(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] sum;
    sum = 8'((int'(a) + int'(b)) % 256);
    m_dm[0] = sum;
    m_rf[2] = sum;
    m_rf[3] = b;
  endtask

  task automatic full_run(input string tag, input logic [7:0] a, input logic [7:0] b);
    int de;
    @(negedge clk);
    reset = 1'b0;
    preload(a, b);
    release_and_run(de);
    apply_model_result(a, b);
    chk({tag, "_done_edge"}, de, 5);
    chk({tag, "_dm0"}, dut.DM1.core[0], m_dm[0]);
    cmp_arrays(tag);
  endtask

  initial begin
    int de;
    logic [7:0] ra, rb;

    // Reset hold with preloaded arrays
    preload(8'd4, 8'd3);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_pc", dut.r_pc, 0);
    cmp_arrays("rst_hold");

    // Basic run
    release_and_run(de);
    apply_model_result(8'd4, 8'd3);
    chk("basic_done_edge", de, 5);
    chk("basic_dm0", dut.DM1.core[0], 7);
    chk("basic_dm1", dut.DM1.core[1], 3);
    chk("basic_r2", dut.RF1.core[2], 7);
    chk("basic_r3", dut.RF1.core[3], 3);
    cmp_arrays("basic");

    // Sticky halt: 20 more edges change nothing
    repeat (20) @(posedge clk);
    #1;
    chk("sticky_done", done, 1);
    chk("sticky_pc", dut.r_pc, 4);
    cmp_arrays("sticky");

    // Mid-run reset after edge 2
    @(negedge clk);
    reset = 1'b0;
    preload(8'd4, 8'd3);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_done", done, 0);
    chk("mid_pc", dut.r_pc, 0);
    m_rf[2] = 8'd4;
    m_rf[3] = 8'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_r2", dut.RF1.core[2], 4);
    chk("mid_r3", dut.RF1.core[3], 3);
    cmp_arrays("mid_hold");
    release_and_run(de);
    apply_model_result(8'd4, 8'd3);
    chk("mid_rerun_done_edge", de, 5);
    chk("mid_rerun_dm0", dut.DM1.core[0], 7);
    cmp_arrays("mid_rerun");

    full_run("overflow", 8'd200, 8'd100);
    chk("overflow_abs", dut.DM1.core[0], 44);
    full_run("zero", 8'd0, 8'd0);
    full_run("max", 8'd255, 8'd255);

    for (int k = 0; k < 6; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      full_run("random", ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
